// File: rtl/apb_regfile_slave.sv
// APB completer: word-addressed register bank behind a 256-byte window, with
// programmable wait states, slave-error response and a saturating write counter.
module apb_regfile_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CA00,
  parameter int          NUM_REGS    = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA7B0_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  output logic [15:0] wr_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic             err_q;
  logic [31:0]      regs [NUM_REGS];

  logic             setup;
  logic [IDX_W-1:0] idx_in;
  logic             err_in;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_err;
  logic             do_write;
  logic             unused_addr_lsb;

  assign setup           = psel_i & ~penable_i;
  assign idx_in          = paddr_i[IDX_W+1:2];
  assign unused_addr_lsb = ^paddr_i[1:0];
  // Out-of-window accesses and writes to the read-only ID slot both error.
  assign err_in = (paddr_i[31:8] != BASE_ADDR[31:8]) | (pwrite_i & (idx_in == '0));

  // With WAIT_CYCLES=0 the response is loaded straight from the setup-cycle bus.
  assign rd_idx = (state == IDLE) ? idx_in : idx_q;
  assign rd_err = (state == IDLE) ? err_in : err_q;

  assign do_write = (state == RESP) & psel_i & penable_i & pready_o & wr_q & ~err_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!psel_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      pready_o  <= 1'b0;
      prdata_o  <= '0;
      pslverr_o <= 1'b0;
      wr_cnt_o  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && setup) begin
        idx_q <= idx_in;
        wr_q  <= pwrite_i;
        err_q <= err_in;
      end
      pready_o  <= (state_nxt == RESP);
      pslverr_o <= (state_nxt == RESP) & rd_err;
      if (state_nxt == RESP) begin
        if (rd_err)               prdata_o <= '0;
        else if (rd_idx == '0)    prdata_o <= ID_VALUE;
        else                      prdata_o <= regs[rd_idx];
      end
      if (do_write) begin
        regs[idx_q] <= pwdata_i;
        if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
      end
    end
  end

endmodule
